sram_tile_reader: RTL
=====================

// Module: sram_tile_reader
// PURPOSE
//  Read-side sequencer for port 2 of the on-chip dual-port SRAM (4096 x 32b, address registered, q unregistered).
//  Streams a rows x cols matrix tile, row-major with programmable row stride, to the systolic-array loader over valid/ready.
//  Handles SRAM read latency and downstream backpressure; no data lost or duplicated. Port 1 stays with the host.
// PARAMETERS
//  ADDR_W  12  SRAM word-address width; all address arithmetic is modulo 2^ADDR_W
//  DATA_W  32  SRAM / stream data width
//  DIM_W   8   width of row and column counts
// PORTS
//  clk             in   1       single clock (SRAM clk2 domain)
//  reset           in   1       synchronous, active-high
//  cfg_start       in   1       1-cycle pulse; latches cfg_* when idle
//  cfg_abort       in   1       flush and return to idle, no done pulse
//  cfg_base        in   ADDR_W  word address of element (0,0)
//  cfg_rows        in   DIM_W   tile rows
//  cfg_cols        in   DIM_W   tile columns
//  cfg_stride      in   ADDR_W  word distance between row starts
//  busy            out  1       high from accepted start until done/abort
//  done            out  1       1-cycle completion pulse
//  sram_address    out  ADDR_W  SRAM port-2 address
//  sram_chipselect out  1       read strobe; one read per asserted cycle
//  sram_write      out  1       constant 0
//  sram_byteenable out  4       constant 4'hF
//  sram_readdata   in   DATA_W  SRAM q_b, valid the cycle after chipselect
//  out_valid       out  1       stream beat valid
//  out_ready       in   1       stream beat accepted when valid & ready
//  out_data        out  DATA_W  element data
//  out_row_last    out  1       beat is last column of a row
//  out_last        out  1       beat is final element of the tile
// BEHAVIOUR
//  Reset: state IDLE, busy=0, done=0, out_valid=0, sram_chipselect=0, sram_address=0, FIFO and counters cleared.
//  FSM IDLE: cfg_start & rows!=0 & cols!=0 -> latch config, busy=1, RUN.
//    cfg_start with rows==0 or cols==0 -> done=1 next cycle, no SRAM access, stay IDLE.
//  RUN: issue reads row-major: addr = row_base + col; row_base starts at cfg_base, += cfg_stride at row end (mod 4096).
//    After the final (rows*cols-th) read is issued -> DRAIN.
//  DRAIN: when FIFO empty and no read in flight -> done=1 for one cycle, busy=0, IDLE.
//  cfg_start while busy is ignored (config not re-latched). cfg_abort in RUN/DRAIN: next cycle IDLE, busy=0,
//    FIFO flushed, in-flight return data discarded, done stays 0; abort in IDLE has no effect. reset has priority over abort.
//  Latency: first sram_chipselect the cycle after cfg_start; each read's data is captured into a 2-entry output
//    FIFO the cycle after its chipselect; out_valid the cycle after capture (FIFO is registered, not fall-through).
//  Credit rule: issue a read only when occupancy + inflight - pop < 2 (pop = out_valid & out_ready this cycle).
//    Gives 1 beat/cycle sustained with out_ready=1; FIFO never overflows under any ready pattern.
//  out_row_last/out_last travel with the data through the FIFO (tagged at issue), held stable while out_valid & !out_ready.
//  out_data/flags hold stable while stalled; out_valid never drops without a handshake (except abort/reset).
//  done fires the cycle after the out_last beat is accepted; busy falls in the same cycle done is high.
//  sram_address holds its last value when chipselect=0.
// TESTING
//  T1 base=0x010 rows=2 cols=3 stride=0x100, ready=1: chipselect 6 consecutive cycles at 010,011,012,110,111,112;
//     beats D[010]..D[112] on consecutive cycles, out_row_last on beats 3 and 6, out_last on 6, done 1 cycle later.
//  T2 as T1 with out_ready low for cycles 3-7 after start: at most 2 beats buffered, chipselect stalls,
//     resumed stream exactly D[010]..D[112] in order, no repeats.
//  T3 wrap: base=0xFFE rows=1 cols=4: addresses FFE,FFF,000,001; out_last on 4th beat.
//  T4 cfg_rows=0 cols=5: done=1 exactly one cycle after start, busy stays 0, sram_chipselect never asserted.
//  T5 cfg_abort after 3rd read of 4x4 tile: busy=0 next cycle, out_valid=0, no done; new start then runs a clean full tile.
//  T6 reset mid-RUN and cfg_start while busy: all outputs return to reset values; start-while-busy leaves config unchanged.

Source files
------------

// File: rtl/sram_tile_reader.sv
// Read sequencer for SRAM port 2: streams a strided rows x cols tile over valid/ready.
// A 2-entry registered FIFO plus credit counting absorbs the one-cycle SRAM read latency.
module sram_tile_reader #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DIM_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [DIM_W-1:0]  cfg_rows,
  input  logic [DIM_W-1:0]  cfg_cols,
  input  logic [ADDR_W-1:0] cfg_stride,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sram_address,
  output logic              sram_chipselect,
  output logic              sram_write,
  output logic [3:0]        sram_byteenable,
  input  logic [DATA_W-1:0] sram_readdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_row_last,
  output logic              out_last
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e            state_q, state_d;
  logic              done_q, done_d;
  logic [DIM_W-1:0]  rows_q, cols_q, row_cnt_q, col_cnt_q;
  logic [ADDR_W-1:0] stride_q, row_base_q, last_addr_q;
  logic              rd_q;
  logic [1:0]        tag_q;
  logic [DATA_W+1:0] fifo_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q, count_d;

  logic              pop, issue, flush, accept, col_end, row_end, credit_ok;
  logic [ADDR_W-1:0] next_addr;
  logic [DATA_W+1:0] head;

  assign flush     = cfg_abort && (state_q != StIdle);
  assign accept    = cfg_start && (state_q == StIdle) && (cfg_rows != '0) && (cfg_cols != '0);
  assign pop       = out_valid && out_ready;
  // Buffered + in-flight beats after this cycle's pop must leave room for one more read.
  assign credit_ok = ({1'b0, count_q} + {2'b00, rd_q}) < (3'd2 + {2'b00, pop});
  assign issue     = (state_q == StRun) && !cfg_abort && credit_ok;
  assign col_end   = (col_cnt_q == cols_q - DIM_W'(1));
  assign row_end   = (row_cnt_q == rows_q - DIM_W'(1));
  assign next_addr = row_base_q + ADDR_W'(col_cnt_q);
  assign count_d   = count_q + {1'b0, rd_q} - {1'b0, pop};

  assign sram_chipselect = issue;
  assign sram_address    = issue ? next_addr : last_addr_q;
  assign sram_write      = 1'b0;
  assign sram_byteenable = 4'hF;

  assign head         = fifo_q[rd_ptr_q];
  assign out_valid    = (count_q != '0);
  assign out_data     = head[DATA_W-1:0];
  assign out_row_last = head[DATA_W+1];
  assign out_last     = head[DATA_W];
  assign busy         = (state_q != StIdle);
  assign done         = done_q;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StRun;
        end else if (cfg_start) begin
          done_d = 1'b1;
        end
      end
      StRun: begin
        if (issue && col_end && row_end) state_d = StDrain;
      end
      StDrain: begin
        if ((count_d == '0) && !rd_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      done_q      <= 1'b0;
      rows_q      <= '0;
      cols_q      <= '0;
      stride_q    <= '0;
      row_cnt_q   <= '0;
      col_cnt_q   <= '0;
      row_base_q  <= '0;
      last_addr_q <= '0;
      rd_q        <= 1'b0;
      tag_q       <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      last_addr_q <= sram_address;
      rd_q        <= issue;
      if (issue) tag_q <= {col_end, col_end && row_end};

      if (accept) begin
        rows_q     <= cfg_rows;
        cols_q     <= cfg_cols;
        stride_q   <= cfg_stride;
        row_cnt_q  <= '0;
        col_cnt_q  <= '0;
        row_base_q <= cfg_base;
      end else if (issue) begin
        if (col_end) begin
          col_cnt_q  <= '0;
          row_cnt_q  <= row_cnt_q + DIM_W'(1);
          row_base_q <= row_base_q + stride_q;
        end else begin
          col_cnt_q <= col_cnt_q + DIM_W'(1);
        end
      end

      // Abort drops buffered beats and the read whose data is still on q.
      if (flush) begin
        rd_q     <= 1'b0;
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
        count_q  <= '0;
      end else begin
        if (rd_q) begin
          fifo_q[wr_ptr_q] <= {tag_q, sram_readdata};
          wr_ptr_q         <= !wr_ptr_q;
        end
        if (pop) rd_ptr_q <= !rd_ptr_q;
        count_q <= count_d;
      end
    end
  end

endmodule
